out_display_7seg: RTL and testbench

//   Downstream consumer of the CPU's 16-bit outvalue bus. Captures outvalue once
//   per display frame and drives a 4-digit multiplexed 7-segment display with hex digits.

---
 rtl/out_display_7seg_if.sv | 28 ++
 rtl/out_display_7seg.sv | 113 +++++++++++
 tb/tb_out_display_7seg.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/out_display_7seg_if.sv
// Bus between the CPU output port and the 7-segment display driver.
// The CPU side drives outvalue/freeze; the display side drives the board pins and frame_tick.
interface out_display_7seg_if;
    logic [15:0] outvalue;
    logic        freeze;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    modport master (
        output outvalue,
        output freeze,
        input  an,
        input  seg,
        input  dp,
        input  frame_tick
    );

    modport slave (
        input  outvalue,
        input  freeze,
        output an,
        output seg,
        output dp,
        output frame_tick
    );
endinterface

// File: rtl/out_display_7seg.sv
// Four-digit multiplexed hex display driver. The value is sampled only at frame
// boundaries so a scan never mixes digits from two different CPU values.
module out_display_7seg #(
    parameter int PRESCALE   = 100000,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b0
) (
    input logic clk,
    input logic reset,
    out_display_7seg_if.slave bus
);

    localparam int                CNT_W   = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [3:0]        AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0]        SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic              DP_OFF  = ACTIVE_LOW;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // A digit is a leading zero when it and every more significant nibble are zero.
    function automatic logic lead_zero(input logic [1:0] k, input logic [15:0] v);
        logic z;
        case (k)
            2'd1:    z = (v[15:4]  == 12'h000);
            2'd2:    z = (v[15:8]  == 8'h00);
            2'd3:    z = (v[15:12] == 4'h0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      disp_q, disp_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_tick_q, frame_tick_d;

    logic             tick;
    logic             capture;
    logic [3:0]       nibble;
    logic [3:0]       an_act;
    logic [6:0]       seg_act;

    always_comb begin
        tick         = (cnt_q == CNT_MAX);
        capture      = tick && (idx_q == 2'd3);

        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        idx_d        = tick ? idx_q + 2'd1 : idx_q;
        disp_d       = (capture && !bus.freeze) ? bus.outvalue : disp_q;
        frame_tick_d = capture;

        // Pin drive is derived from the current slot so it lags idx/disp by one clock.
        nibble       = disp_q[{idx_q, 2'b00} +: 4];
        an_act       = 4'b0001 << idx_q;
        seg_act      = (BLANK_LZ && lead_zero(idx_q, disp_q)) ? 7'h00 : hex7(nibble);

        an_d         = ACTIVE_LOW ? ~an_act  : an_act;
        seg_d        = ACTIVE_LOW ? ~seg_act : seg_act;
        dp_d         = DP_OFF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'h0000;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_out_display_7seg.sv
// Directed bench for the 7-segment driver: one instance without and one with
// leading-zero blanking, both fed the same CPU value.
module tb_out_display_7seg;

    logic        clk;
    logic        reset;
    logic [15:0] outvalue;
    logic        freeze;
    int          checks;
    int          errors;

    out_display_7seg_if bus ();
    out_display_7seg_if bus_lz ();

    assign bus.outvalue    = outvalue;
    assign bus.freeze      = freeze;
    assign bus_lz.outvalue = outvalue;
    assign bus_lz.freeze   = freeze;

    out_display_7seg #(.PRESCALE(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    out_display_7seg #(.PRESCALE(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut_lz (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_lz.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Wait for a frame_tick sample; leaves the bench at the negedge where it is seen.
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) seen = 1'b1;
        end
        chk("sync_tick", {31'd0, seen}, 32'd1);
    endtask

    // Checks one full frame starting just after a frame boundary. es/el hold the
    // expected seg codes {d3,d2,d1,d0}; at sample chg_at the CPU inputs are changed.
    task automatic check_frame(input string tag, input logic [27:0] es, input logic [27:0] el,
                               input int chg_at, input logic [15:0] chg_val, input logic chg_frz);
        logic [15:0] an_seq;
        int          d;
        an_seq = 16'h7BDE;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            d = i / 4;
            chk({tag, "_an"},  {28'd0, bus.an},       {28'd0, an_seq[4*d +: 4]});
            chk({tag, "_seg"}, {25'd0, bus.seg},      {25'd0, es[7*d +: 7]});
            chk({tag, "_lz"},  {25'd0, bus_lz.seg},   {25'd0, el[7*d +: 7]});
            chk({tag, "_ft"},  {31'd0, bus.frame_tick}, {31'd0, (i == 15)});
            if (i == 0) chk({tag, "_dp"}, {31'd0, bus.dp}, 32'd1);
            if (i == chg_at) begin
                outvalue = chg_val;
                freeze   = chg_frz;
            end
        end
    endtask

    initial begin
        int ft_cnt;
        int bad;
        int zeros;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        outvalue = 16'h0000;
        freeze   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_an",  {28'd0, bus.an},  32'h0000000F);
        chk("rst_seg", {25'd0, bus.seg}, 32'h0000007F);
        chk("rst_dp",  {31'd0, bus.dp},  32'd1);
        chk("rst_ft",  {31'd0, bus.frame_tick}, 32'd0);
        reset = 1'b0;

        @(negedge clk);
        chk("first_an",  {28'd0, bus.an},     32'h0000000E);
        chk("first_seg", {25'd0, bus.seg},    32'h00000040);
        chk("first_lz",  {25'd0, bus_lz.seg}, 32'h00000040);
        outvalue = 16'h1234;
        wait_tick();

        check_frame("f1234a", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, -1, 16'h1234, 1'b0);
        check_frame("f1234b", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 5, 16'hABCD, 1'b0);
        check_frame("fabcd",  {7'h08, 7'h03, 7'h46, 7'h21}, {7'h08, 7'h03, 7'h46, 7'h21}, 3, 16'hFFFF, 1'b1);
        check_frame("frz",    {7'h08, 7'h03, 7'h46, 7'h21}, {7'h08, 7'h03, 7'h46, 7'h21}, 8, 16'hFFFF, 1'b0);
        check_frame("fffffa", {7'h0E, 7'h0E, 7'h0E, 7'h0E}, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, 14, 16'h0040, 1'b1);
        freeze = 1'b0;
        check_frame("frzedge", {7'h0E, 7'h0E, 7'h0E, 7'h0E}, {7'h0E, 7'h0E, 7'h0E, 7'h0E}, -1, 16'h0040, 1'b0);
        check_frame("f0040",  {7'h40, 7'h40, 7'h19, 7'h40}, {7'h7F, 7'h7F, 7'h19, 7'h40}, 2, 16'h0000, 1'b0);
        check_frame("f0000",  {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, -1, 16'h0000, 1'b0);

        ft_cnt = 0;
        bad    = 0;
        for (int c = 0; c < 1600; c++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) ft_cnt++;
            zeros = 0;
            for (int k = 0; k < 4; k++) if (bus.an[k] === 1'b0) zeros++;
            if (zeros != 1 || bus_lz.an !== bus.an) bad++;
        end
        chk("frames_100", ft_cnt, 32'd100);
        chk("an_onehot",  bad,    32'd0);

        check_frame("pre_rst", {7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 0, 16'h1234, 1'b0);
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_an",  {28'd0, bus.an},  32'h0000000F);
        chk("mid_rst_seg", {25'd0, bus.seg}, 32'h0000007F);
        chk("mid_rst_dp",  {31'd0, bus.dp},  32'd1);
        chk("mid_rst_ft",  {31'd0, bus.frame_tick}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_an",  {28'd0, bus.an},     32'h0000000E);
        chk("post_rst_seg", {25'd0, bus.seg},    32'h00000040);
        chk("post_rst_lz",  {25'd0, bus_lz.seg}, 32'h00000040);
        wait_tick();
        check_frame("post_rst", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, -1, 16'h1234, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
